// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and sizing helpers for the UART transmit arbiter.
//   arb_state_e : arbiter FSM state encoding (IDLE, START, WAIT, GAP)
//   cnt_width   : bit width for a counter that runs 0 .. max_val-1
//   IDX_W/GAP_W/TO_W : widths for the default configuration
// Optional feature macro used by the arbiter: UART_ARB_TIMEOUT_EN
// -----------------------------------------------------------------------------
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } arb_state_e;

    // Width of a counter covering 0 .. max_val-1, never narrower than 1 bit
    function automatic int cnt_width(input int max_val);
        int w;
        if (max_val < 2) begin
            w = 1;
        end else begin
            w = $clog2(max_val);
        end
        return w;
    endfunction

    localparam int N_REQ_DEF          = 4;
    localparam int GAP_CYCLES_DEF     = 16;
    localparam int TIMEOUT_CYCLES_DEF = 131072;

    localparam int IDX_W = cnt_width(N_REQ_DEF);
    localparam int GAP_W = cnt_width(GAP_CYCLES_DEF);
    localparam int TO_W  = cnt_width(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin search: returns the first set request strictly
// after ptr, wrapping from N_REQ-1 back to 0 (ptr itself is checked last).
// Ports:
//   req   in  N_REQ  request vector
//   ptr   in  IW     index of the most recently served source
//   valid out 1      any request present
//   idx   out IW     selected source (0 when valid is low)
// -----------------------------------------------------------------------------
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    localparam int IW    = cnt_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             valid,
    output logic [IW-1:0]    idx
);

    logic [IW-1:0] idx_s;
    logic [IW-1:0] cand_s;

    // Scan offsets from farthest to nearest so the nearest set request wins
    always_comb begin
        idx_s  = '0;
        cand_s = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand_s = IW'((int'(ptr) + i) % N_REQ);
            if (req[cand_s]) begin
                idx_s = cand_s;
            end else begin
                idx_s = idx_s;
            end
        end
    end

    assign valid = |req;
    assign idx   = idx_s;

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among N_REQ byte sources. Round-robin grant,
// one byte per grant, 1-cycle tx_start, wait for tx_done, then an idle gap.
// Optional macro UART_ARB_TIMEOUT_EN adds a tx_start-to-tx_done watchdog
// with a sticky timeout_err flag; without it timeout_err is constant 0.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   req          level request per source, held until ack
//   req_data     byte of source i at [i*DATA_W +: DATA_W]
//   ack          1-cycle pulse: byte of that source latched
//   tx_start     1-cycle start pulse to the transmitter
//   tx_data      latched byte for the transmitter
//   tx_done      1-cycle frame-complete pulse from the transmitter
//   busy         high whenever the FSM is not IDLE
//   grant_id     index of the current/last granted source
//   timeout_err  sticky watchdog flag
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int N_REQ          = N_REQ_DEF,
    parameter  int DATA_W         = 8,
    parameter  int GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter  int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    localparam int IW             = cnt_width(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_done,
    output logic                    busy,
    output logic [IW-1:0]           grant_id,
    output logic                    timeout_err
);

    localparam int GW = cnt_width(GAP_CYCLES);

    arb_state_e         state_r;
    logic [IW-1:0]      rr_ptr_r;
    logic [GW-1:0]      gap_cnt_r;
    logic [N_REQ-1:0]   ack_r;
    logic               tx_start_r;
    logic [DATA_W-1:0]  tx_data_r;
    logic               busy_r;
    logic [IW-1:0]      grant_id_r;
    logic               pick_valid_s;
    logic [IW-1:0]      pick_idx_s;
    logic               wait_end_s;

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req   (req),
        .ptr   (rr_ptr_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = cnt_width(TIMEOUT_CYCLES);

    logic [TW-1:0] to_cnt_r;
    logic          timeout_err_r;
    logic          to_hit_s;

    assign to_hit_s   = (to_cnt_r == TW'(TIMEOUT_CYCLES - 1));
    // tx_done takes priority over a timeout landing on the same cycle
    assign wait_end_s = tx_done | to_hit_s;

    // Watchdog: cleared on START, counts WAIT cycles, flags a missing tx_done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_r      <= '0;
            timeout_err_r <= 1'b0;
        end else if (state_r == START) begin
            to_cnt_r      <= '0;
            timeout_err_r <= timeout_err_r;
        end else if (state_r == WAIT) begin
            to_cnt_r <= to_cnt_r + TW'(1);
            if (!tx_done && to_hit_s) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end else begin
            to_cnt_r      <= to_cnt_r;
            timeout_err_r <= timeout_err_r;
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign wait_end_s  = tx_done;
    assign timeout_err = 1'b0;
`endif

    // Arbiter FSM with registered ack/tx_start/tx_data/busy/grant_id
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            rr_ptr_r   <= IW'(N_REQ - 1);
            gap_cnt_r  <= '0;
            ack_r      <= '0;
            tx_start_r <= 1'b0;
            tx_data_r  <= '0;
            busy_r     <= 1'b0;
            grant_id_r <= '0;
        end else begin
            ack_r      <= '0;
            tx_start_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        tx_data_r         <= req_data[pick_idx_s*DATA_W +: DATA_W];
                        grant_id_r        <= pick_idx_s;
                        rr_ptr_r          <= pick_idx_s;
                        ack_r[pick_idx_s] <= 1'b1;
                        busy_r            <= 1'b1;
                        state_r           <= START;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                START: begin
                    // Pulse lands in the cycle after ack, one cycle per grant
                    tx_start_r <= 1'b1;
                    busy_r     <= 1'b1;
                    state_r    <= WAIT;
                end
                WAIT: begin
                    gap_cnt_r <= '0;
                    if (wait_end_s) begin
                        if (GAP_CYCLES == 0) begin
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            busy_r  <= 1'b1;
                            state_r <= GAP;
                        end
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= WAIT;
                    end
                end
                GAP: begin
                    if (gap_cnt_r == GW'(GAP_CYCLES - 1)) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GW'(1);
                        busy_r    <= 1'b1;
                        state_r   <= GAP;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ack      = ack_r;
    assign tx_start = tx_start_r;
    assign tx_data  = tx_data_r;
    assign busy     = busy_r;
    assign grant_id = grant_id_r;

endmodule
